ps2_packet_rx: RTL and testbench

PS2_PACKET_RX -- requirements
Module: ps2_packet_rx

---
 rtl/ps2_packet_rx.sv | 153 +++++++++++++++
 tb/tb_ps2_packet_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_packet_rx.sv
// PS/2 device-to-host receiver: synchronises and glitch-filters the PS/2 lines,
// deframes 11-bit frames and assembles multi-byte packets with error reporting.
module ps2_packet_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int PACKET_BYTES   = 3,
  parameter bit SYNC_CHECK     = 1'b1
) (
  input  logic                      CLK50MHZ,
  input  logic                      RST,
  input  logic                      ps2c,
  input  logic                      ps2d,
  output logic [8*PACKET_BYTES-1:0] packet,
  output logic                      packet_valid,
  output logic                      err_parity,
  output logic                      err_frame,
  output logic                      err_sync,
  output logic                      err_timeout,
  output logic                      busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                    state, state_n;
  logic                      c_meta, c_sync, d_meta, d_sync;
  logic                      fclk;
  logic [7:0]                fcnt;
  logic                      fall;
  logic [2:0]                bitcnt;
  logic [7:0]                shreg;
  logic                      pbit;
  logic [1:0]                idx;
  logic [8*PACKET_BYTES-1:0] hold, hold_n;
  logic [TW-1:0]             tcnt;
  logic                      timeout, stop_fin, frame_bad, par_bad, sync_bad;
  logic                      accept, last;

  // The filtered falling edge is the cycle in which fclk is about to drop.
  assign fall = fclk && !c_sync && (fcnt == 8'(FILTER_LEN - 1));
  assign busy = (state != IDLE) || (idx != '0);

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      c_meta <= 1'b1;
      c_sync <= 1'b1;
      d_meta <= 1'b1;
      d_sync <= 1'b1;
      fclk   <= 1'b1;
      fcnt   <= '0;
    end else begin
      c_meta <= ps2c;
      c_sync <= c_meta;
      d_meta <= ps2d;
      d_sync <= d_meta;
      if (c_sync == fclk) begin
        fcnt <= '0;
      end else if (fcnt == 8'(FILTER_LEN - 1)) begin
        fclk <= c_sync;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 8'd1;
      end
    end
  end

  always_comb begin
    stop_fin  = fall && (state == STOP);
    frame_bad = stop_fin && !d_sync;
    par_bad   = stop_fin && d_sync && !(^{shreg, pbit});
    sync_bad  = stop_fin && d_sync && (^{shreg, pbit}) && SYNC_CHECK &&
                (idx == '0) && !shreg[3];
    accept    = stop_fin && d_sync && (^{shreg, pbit}) && !sync_bad;
    last      = accept && (idx == 2'(PACKET_BYTES - 1));
    timeout   = !fall && busy && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    hold_n    = hold;
    hold_n[8*idx +: 8] = shreg;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (fall && !d_sync) state_n = DATA;
      DATA:    if (fall && (bitcnt == 3'd7)) state_n = PARITY;
      PARITY:  if (fall) state_n = STOP;
      STOP:    if (fall) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (timeout) state_n = IDLE;
  end

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      bitcnt       <= '0;
      shreg        <= '0;
      pbit         <= 1'b0;
      idx          <= '0;
      hold         <= '0;
      packet       <= '0;
      tcnt         <= '0;
      packet_valid <= 1'b0;
      err_parity   <= 1'b0;
      err_frame    <= 1'b0;
      err_sync     <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      packet_valid <= last;
      err_frame    <= frame_bad;
      err_parity   <= par_bad;
      err_sync     <= sync_bad;
      err_timeout  <= timeout;

      if (fall || timeout || !busy) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end

      if (fall && (state == IDLE)) begin
        bitcnt <= '0;
      end
      if (fall && (state == DATA)) begin
        shreg  <= {d_sync, shreg[7:1]};
        bitcnt <= bitcnt + 3'd1;
      end
      if (fall && (state == PARITY)) begin
        pbit <= d_sync;
      end

      if (timeout || frame_bad || par_bad) begin
        idx <= '0;
      end else if (accept) begin
        hold <= hold_n;
        if (last) begin
          packet <= hold_n;
          idx    <= '0;
        end else begin
          idx <= idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_packet_rx.sv
// Directed bench for ps2_packet_rx: packet assembly, parity/frame/sync errors,
// glitch rejection, timeout and mid-frame reset, with an accelerated PS/2 clock.
module tb_ps2_packet_rx;

  localparam int FL = 8;
  localparam int TO = 2000;
  localparam int PB = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ps2c, ps2d;
  logic [23:0]   packet;
  logic          packet_valid, err_parity, err_frame, err_sync, err_timeout, busy;

  int total = 0;
  int bad   = 0;

  int pv_cnt = 0, ep_cnt = 0, ef_cnt = 0, es_cnt = 0, et_cnt = 0, multi_cnt = 0;
  int b_pv, b_ep, b_ef, b_es, b_et, b_multi;
  logic [23:0] pv_pkt = '0;

  ps2_packet_rx #(
    .FILTER_LEN(FL),
    .TIMEOUT_CYCLES(TO),
    .PACKET_BYTES(PB),
    .SYNC_CHECK(1'b1)
  ) dut (
    .CLK50MHZ(clk),
    .RST(rst_n),
    .ps2c(ps2c),
    .ps2d(ps2d),
    .packet(packet),
    .packet_valid(packet_valid),
    .err_parity(err_parity),
    .err_frame(err_frame),
    .err_sync(err_sync),
    .err_timeout(err_timeout),
    .busy(busy)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (packet_valid) begin
      pv_cnt <= pv_cnt + 1;
      pv_pkt <= packet;
    end
    if (err_parity)  ep_cnt <= ep_cnt + 1;
    if (err_frame)   ef_cnt <= ef_cnt + 1;
    if (err_sync)    es_cnt <= es_cnt + 1;
    if (err_timeout) et_cnt <= et_cnt + 1;
    if ((32'(packet_valid) + 32'(err_parity) + 32'(err_frame) +
         32'(err_sync) + 32'(err_timeout)) > 1)
      multi_cnt <= multi_cnt + 1;
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_pv = pv_cnt; b_ep = ep_cnt; b_ef = ef_cnt;
    b_es = es_cnt; b_et = et_cnt; b_multi = multi_cnt;
  endtask

  task automatic chk_pulses(input string tag, input int pv, input int ep,
                            input int ef, input int es, input int et);
    chk({tag, ".valid"},   32'(pv_cnt - b_pv), 32'(pv));
    chk({tag, ".parity"},  32'(ep_cnt - b_ep), 32'(ep));
    chk({tag, ".frame"},   32'(ef_cnt - b_ef), 32'(ef));
    chk({tag, ".sync"},    32'(es_cnt - b_es), 32'(es));
    chk({tag, ".timeout"}, 32'(et_cnt - b_et), 32'(et));
    chk({tag, ".overlap"}, 32'(multi_cnt - b_multi), 32'd0);
  endtask

  // Bits go out LSB first; each bit is 80 clk cycles with a 40-cycle low phase.
  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2d = bits[i];
      wclk(20);
      ps2c = 1'b0;
      wclk(40);
      ps2c = 1'b1;
      wclk(20);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic pinv, input logic stopv);
    logic [10:0] f;
    f = {stopv, (~^b) ^ pinv, b, 1'b0};
    send_bits(f, 11);
    ps2d = 1'b1;
    wclk(200);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_byte(b, 1'b0, 1'b1);
  endtask

  initial begin
    logic [10:0] part;
    rst_n = 1'b0;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    wclk(5);
    chk("reset.packet", 32'(packet), 32'h0);
    chk("reset.valid",  32'(packet_valid), 32'h0);
    chk("reset.errs",   32'({err_parity, err_frame, err_sync, err_timeout}), 32'h0);
    chk("reset.busy",   32'(busy), 32'h0);
    rst_n = 1'b1;
    wclk(50);

    // Basic packet.
    snap();
    send_good(8'h08);
    chk("basic.busy_mid", 32'(busy), 32'h1);
    send_good(8'h01);
    send_good(8'hFF);
    chk_pulses("basic", 1, 0, 0, 0, 0);
    chk("basic.pv_pkt", 32'(pv_pkt), 32'hFF0108);
    chk("basic.packet", 32'(packet), 32'hFF0108);
    chk("basic.busy",   32'(busy), 32'h0);

    // Parity error on second byte drops the partial packet.
    snap();
    send_good(8'h08);
    send_byte(8'h01, 1'b1, 1'b1);
    chk_pulses("parity", 0, 1, 0, 0, 0);
    chk("parity.busy", 32'(busy), 32'h0);
    chk("parity.hold", 32'(packet), 32'hFF0108);
    snap();
    send_good(8'h09);
    send_good(8'h02);
    send_good(8'h03);
    chk_pulses("after_par", 1, 0, 0, 0, 0);
    chk("after_par.packet", 32'(packet), 32'h030209);

    // Sync check rejects a first byte without bit 3.
    snap();
    send_good(8'h00);
    chk_pulses("sync", 0, 0, 0, 1, 0);
    chk("sync.busy", 32'(busy), 32'h0);
    snap();
    send_good(8'h08);
    send_good(8'h00);
    send_good(8'h00);
    chk_pulses("after_sync", 1, 0, 0, 0, 0);
    chk("after_sync.packet", 32'(packet), 32'h000008);

    // Stop bit 0 is a frame error, and wins over a simultaneous parity error.
    snap();
    send_good(8'h08);
    send_byte(8'h01, 1'b0, 1'b0);
    chk_pulses("frame", 0, 0, 1, 0, 0);
    chk("frame.busy", 32'(busy), 32'h0);
    snap();
    send_byte(8'h08, 1'b1, 1'b0);
    chk_pulses("frame_par", 0, 0, 1, 0, 0);

    // Low glitch one cycle shorter than the filter, with data low as a fake start.
    snap();
    ps2d = 1'b0;
    ps2c = 1'b0;
    wclk(FL - 1);
    ps2c = 1'b1;
    for (int i = 0; i < 30; i++) begin
      total++;
      assert (busy === 1'b0) else begin
        bad++;
        $error("FAIL glitch.busy[%0d]: observed=%0h expected=0", i, busy);
      end
      wclk(1);
    end
    ps2d = 1'b1;
    wclk(100);
    chk_pulses("glitch", 0, 0, 0, 0, 0);
    chk("glitch.busy", 32'(busy), 32'h0);

    // Timeout on a partial packet.
    snap();
    send_good(8'h08);
    send_good(8'h01);
    wclk(1500);
    chk("timeout.busy_before", 32'(busy), 32'h1);
    chk_pulses("timeout_early", 0, 0, 0, 0, 0);
    wclk(500);
    chk_pulses("timeout", 0, 0, 0, 0, 1);
    chk("timeout.busy_after", 32'(busy), 32'h0);
    snap();
    send_good(8'h0A);
    send_good(8'h0B);
    send_good(8'h0C);
    chk_pulses("after_to", 1, 0, 0, 0, 0);
    chk("after_to.packet", 32'(packet), 32'h0C0B0A);

    // Reset in the middle of a frame (start + 4 data bits sent).
    snap();
    part = {1'b1, 1'b0, 8'h08, 1'b0};
    send_bits(part, 5);
    chk("rst.busy_before", 32'(busy), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst.packet", 32'(packet), 32'h0);
    chk("rst.busy",   32'(busy), 32'h0);
    chk("rst.pulses", 32'({packet_valid, err_parity, err_frame, err_sync, err_timeout}), 32'h0);
    wclk(5);
    rst_n = 1'b1;
    ps2d  = 1'b1;
    wclk(300);
    chk_pulses("rst_release", 0, 0, 0, 0, 0);
    chk("rst_release.busy",   32'(busy), 32'h0);
    chk("rst_release.packet", 32'(packet), 32'h0);
    snap();
    send_good(8'h18);
    send_good(8'h22);
    send_good(8'h33);
    chk_pulses("after_rst", 1, 0, 0, 0, 0);
    chk("after_rst.packet", 32'(packet), 32'h332218);
    chk("after_rst.pv_pkt", 32'(pv_pkt), 32'h332218);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
